lc3_ea_mem_ctrl: RTL
====================

# lc3_ea_mem_ctrl

Sequencer for LC-3 data-memory instructions (LD, LDI, LDR, LEA, ST, STI, STR). It accepts one instruction at a time and drives the select lines of the shared address adder/mux block. It latches the effective address into an internal MAR and runs the memory read/write handshake, including the extra pointer fetch for indirect modes. It sits between the instruction decode/FSM and the memory interface, and delivers load results to register-file writeback.

## Interface
- TIMEOUT, 15: maximum cycles a memory state waits for `i_mem_ready` before aborting; range 1..255.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  request pulse; sampled only in IDLE.
- i_ir  in  16  instruction word; latched when `i_start` is accepted.
- i_st_data  in  16  store source value (SR); latched when `i_start` is accepted.
- i_addermux_out  in  16  sum returned by the address adder.
- i_mem_rdata  in  16  memory read data; valid when `i_mem_ready`=1.
- i_mem_ready  in  1  memory completes the current transfer this cycle.
- o_ir  out  16  latched IR; bits [10:0], [8:0] and [5:0] feed the adder's IR-field inputs.
- o_base_reg  out  3  `o_ir[8:6]`; register-file read address for the adder's SR1 input.
- o_addr1mux  out  1  0 selects PC, 1 selects SR1.
- o_addr2mux  out  2  00 selects 0, 01 selects IR[5:0], 10 selects IR[8:0], 11 selects IR[10:0].
- o_mem_req, o_mem_we  out  1 each  memory request and write-enable.
- o_mem_addr  out  16  equals the MAR.
- o_mem_wdata  out  16  equals latched `i_st_data`.
- o_busy  out  1  high whenever the state is not IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  one-cycle error pulse; coincides with `o_done`.
- o_ld_reg  out  1  one-cycle register write strobe; coincides with `o_done`.
- o_dr  out  3  `o_ir[11:9]`.
- o_result  out  16  load data, or the effective address for LEA.

## Operation
- States: IDLE, EA, IND, RD, WR, DONE.
- IDLE: on `i_start`=1, latch `i_ir` and `i_st_data`, then go to EA. Opcodes outside the supported set go to DONE with the error flag set.
- EA: drive the adder selects from the latched opcode:
  - LD, LDI, LEA, ST, STI: addr1mux=0, addr2mux=10.
  - LDR, STR: addr1mux=1, addr2mux=01.
  - MAR ← `i_addermux_out` at the end of EA.
  - Next state: LEA → DONE (result ← sum); LD, LDR → RD; ST, STR → WR; LDI, STI → IND.
- IND: read with `o_mem_req`=1 and `o_mem_we`=0. On `i_mem_ready`: MAR ← `i_mem_rdata`; LDI → RD, STI → WR.
- RD: read. On `i_mem_ready`: result ← `i_mem_rdata`, then go to DONE.
- WR: write with `o_mem_req`=1 and `o_mem_we`=1. On `i_mem_ready`, go to DONE.
- DONE: assert `o_done` for one cycle, then go to IDLE.
  - `o_ld_reg`=1 only for LD, LDI, LDR and LEA with no error.
  - `o_err`=1 for an unsupported opcode or a timeout.
- Wait counter: cleared on entry to IND, RD or WR; increments each cycle that `i_mem_ready`=0. When it reaches TIMEOUT with ready still low, abort to DONE with `o_err`=1, `o_ld_reg`=0 and the result unchanged.
- `i_start` is ignored while busy; no queuing.
- Outside EA, the adder selects hold 0/00.
- Memory addresses and sums wrap modulo 2^16; the adder's sign extension is authoritative.

## Timing
- Reset (async, immediate): state=IDLE. All outputs 0, including `o_mem_req`, `o_mem_we`, `o_ir`, the MAR, `o_result`, `o_mem_wdata` and the counter. A transfer in flight is dropped with no `o_done`.
- Latency is counted from the edge that accepts `i_start` to the cycle in which `o_done` is high, with `i_mem_ready` tied to 1:
  - LEA and unsupported opcodes: 2.
  - LD, LDR, ST, STR: 3.
  - LDI, STI: 4.
  - Each wait cycle adds 1.
- `o_mem_addr`, `o_mem_we` and `o_mem_wdata` are stable for the whole time `o_mem_req` is high. `o_mem_req` drops in the cycle after ready is seen.
- `i_start` in the DONE cycle is ignored. The earliest re-accept is the first IDLE cycle, so back-to-back throughput is one instruction per latency+1 cycles.
- `i_mem_ready` asserted outside IND, RD and WR is ignored.

## Test plan
- LEA: IR=0xE1FF, PC=0x3000 → addr1mux=0 and addr2mux=10 in EA; `o_result`=0x2FFF, `o_dr`=0, `o_ld_reg`=1 at +2.
- LDR with R2=0x4000: IR=0x6CBF (DR=6, offset −1) → addr1mux=1, addr2mux=01, `o_mem_addr`=0x3FFF; with mem[0x3FFF]=0xBEEF, `o_result`=0xBEEF and `o_dr`=6 at +3.
- STI: PC=0x3000, IR=0xB002, mem[0x3002]=0x5000, SR value=0x1234 → IND reads 0x3002, then WR to 0x5000 with wdata 0x1234 and we=1; `o_done` at +4, `o_ld_reg`=0.
- LD with ready delayed 3 cycles: `o_done` at +6. Second `i_start` pulses while busy are ignored (`o_done` pulses exactly once).
- Timeout: TIMEOUT=4, LD with ready stuck at 0 → after 4 wait cycles, `o_done`=`o_err`=1, `o_ld_reg`=0, `o_mem_req` low. An unsupported opcode (ADD, 0x1042) gives `o_err` at +2.
- Reset mid-RD with `o_mem_req`=1 → `o_mem_req`, `o_busy` and `o_result` go to 0 immediately, no `o_done`; a new LD after reset completes normally.

Source files
------------

// File: rtl/lc3_ea_mem_ctrl.sv
// LC-3 data-memory instruction sequencer: drives the address adder selects,
// holds the MAR, runs the memory handshake (with pointer fetch for LDI/STI).
module lc3_ea_mem_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_ir,
  input  logic [15:0] i_st_data,
  input  logic [15:0] i_addermux_out,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic [15:0] o_ir,
  output logic [2:0]  o_base_reg,
  output logic        o_addr1mux,
  output logic [1:0]  o_addr2mux,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_ld_reg,
  output logic [2:0]  o_dr,
  output logic [15:0] o_result
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_EA = 3'd1, S_IND = 3'd2, S_RD = 3'd3, S_WR = 3'd4, S_DONE = 3'd5
  } state_t;

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LEA = 4'b1110;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_STR = 4'b0111;
  // Last count value before the wait budget runs out.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d, wdata_q, wdata_d, mar_q, mar_d, result_q, result_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [3:0] opcode;
  logic       is_load, is_reg_base, is_pc_base, mem_state, wait_expired;

  assign opcode       = ir_q[15:12];
  assign is_load      = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_LDR) || (opcode == OP_LEA);
  assign is_reg_base  = (opcode == OP_LDR) || (opcode == OP_STR);
  assign is_pc_base   = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_LEA) ||
                        (opcode == OP_ST) || (opcode == OP_STI);
  assign mem_state    = (state_q == S_IND) || (state_q == S_RD) || (state_q == S_WR);
  assign wait_expired = !i_mem_ready && (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      ir_q     <= 16'h0000;
      wdata_q  <= 16'h0000;
      mar_q    <= 16'h0000;
      result_q <= 16'h0000;
      cnt_q    <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      wdata_q  <= wdata_d;
      mar_q    <= mar_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = i_start ? S_EA : S_IDLE;
      S_EA: begin
        case (opcode)
          OP_LD, OP_LDR:  state_d = S_RD;
          OP_ST, OP_STR:  state_d = S_WR;
          OP_LDI, OP_STI: state_d = S_IND;
          default:        state_d = S_DONE;
        endcase
      end
      S_IND: begin
        if (i_mem_ready)       state_d = (opcode == OP_LDI) ? S_RD : S_WR;
        else if (wait_expired) state_d = S_DONE;
        else                   state_d = S_IND;
      end
      S_RD, S_WR: begin
        if (i_mem_ready || wait_expired) state_d = S_DONE;
        else                             state_d = state_q;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: latching, MAR/result capture, wait counter, error flag.
  always_comb begin
    ir_d     = ir_q;
    wdata_d  = wdata_q;
    mar_d    = mar_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = 8'h00;
    if (state_q == S_IDLE) begin
      if (i_start) begin
        ir_d    = i_ir;
        wdata_d = i_st_data;
        err_d   = 1'b0;
      end
    end else if (state_q == S_EA) begin
      if (is_pc_base || is_reg_base) begin
        mar_d = i_addermux_out;
        if (opcode == OP_LEA) result_d = i_addermux_out;
      end else begin
        err_d = 1'b1;
      end
    end else if (mem_state) begin
      if (i_mem_ready) begin
        if (state_q == S_IND) mar_d = i_mem_rdata;
        if (state_q == S_RD)  result_d = i_mem_rdata;
      end else if (wait_expired) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      cnt_d = 8'h00;
    end
  end

  always_comb begin
    o_addr1mux = 1'b0;
    o_addr2mux = 2'b00;
    if (state_q == S_EA) begin
      if (is_reg_base) begin
        o_addr1mux = 1'b1;
        o_addr2mux = 2'b01;
      end else if (is_pc_base) begin
        o_addr2mux = 2'b10;
      end else begin
        o_addr2mux = 2'b00;
      end
    end else begin
      o_addr1mux = 1'b0;
    end
  end

  assign o_mem_req   = mem_state;
  assign o_mem_we    = (state_q == S_WR);
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_err       = o_done && err_q;
  assign o_ld_reg    = o_done && is_load && !err_q;
  assign o_ir        = ir_q;
  assign o_base_reg  = ir_q[8:6];
  assign o_dr        = ir_q[11:9];
  assign o_mem_addr  = mar_q;
  assign o_mem_wdata = wdata_q;
  assign o_result    = result_q;

endmodule
